// File: rtl/llki_pkg.sv
// rtl/llki_pkg.sv - shared TL-UL constants and loader types for the LLKI loader path.
package llki_pkg;

   localparam int DEF_TL_AW  = 32;
   localparam int DEF_TL_DW  = 64;
   localparam int DEF_TL_AIW = 8;
   localparam int DEF_TL_DIW = 1;
   localparam int DEF_TL_SZW = 2;

   localparam logic [2:0] TL_OP_PUTFULL       = 3'h0;
   localparam logic [2:0] TL_OP_ACCESSACK     = 3'h0;
   localparam logic [2:0] TL_OP_ACCESSACKDATA = 3'h1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } loader_state_e;

endpackage

// File: rtl/scratchpad_tl_loader.sv
// rtl/scratchpad_tl_loader.sv - TL-UL master streaming 64-bit words into the scratchpad slave port.
module scratchpad_tl_loader
   import llki_pkg::*;
#(
   parameter int TL_SZW          = DEF_TL_SZW,
   parameter int TL_AIW          = DEF_TL_AIW,
   parameter int TL_AW           = DEF_TL_AW,
   parameter int TL_DW           = DEF_TL_DW,
   parameter int TL_DBW          = TL_DW / 8,
   parameter int TL_DIW          = DEF_TL_DIW,
   parameter int SOURCE_ID       = 0,
   parameter int MAX_OUTSTANDING = 4,
   parameter int COUNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [TL_AW-1:0]  base_addr,
   input  logic [COUNT_W-1:0] word_count,
   input  logic              src_valid,
   input  logic [TL_DW-1:0]  src_data,
   output logic              src_ready,
   output logic [2:0]        master_a_opcode,
   output logic [2:0]        master_a_param,
   output logic [TL_SZW-1:0] master_a_size,
   output logic [TL_AIW-1:0] master_a_source,
   output logic [TL_AW-1:0]  master_a_address,
   output logic [TL_DBW-1:0] master_a_mask,
   output logic [TL_DW-1:0]  master_a_data,
   output logic              master_a_corrupt,
   output logic              master_a_valid,
   input  logic              master_a_ready,
   input  logic [2:0]        master_d_opcode,
   input  logic [2:0]        master_d_param,
   input  logic [TL_SZW-1:0] master_d_size,
   input  logic [TL_AIW-1:0] master_d_source,
   input  logic [TL_DIW-1:0] master_d_sink,
   input  logic              master_d_denied,
   input  logic [TL_DW-1:0]  master_d_data,
   input  logic              master_d_corrupt,
   input  logic              master_d_valid,
   output logic              master_d_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int OUT_W = 3;

   loader_state_e       state_q, state_d;
   logic [COUNT_W-1:0]  beat_idx_q, beat_idx_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic [TL_AW-1:0]    base_q, base_d;
   logic [OUT_W-1:0]    outstanding_q, outstanding_d;
   logic                err_q, err_d;

   logic credit, a_fire, d_fire, start_acc, misaligned, last_beat, d_bad, d_orphan;
   logic unused_d;

   assign unused_d = ^{master_d_param, master_d_size, master_d_source, master_d_sink, master_d_data};

   assign master_a_opcode  = TL_OP_PUTFULL;
   assign master_a_param   = 3'h0;
   assign master_a_size    = TL_SZW'(3);
   assign master_a_source  = TL_AIW'(SOURCE_ID);
   assign master_a_mask    = '1;
   assign master_a_corrupt = 1'b0;
   assign master_a_data    = src_data;
   assign master_a_address = base_q + (TL_AW'(beat_idx_q) << 3);
   assign master_d_ready   = 1'b1;

   assign credit         = (state_q == ISSUE) && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
   assign master_a_valid = src_valid & credit;
   assign src_ready      = master_a_ready & credit;
   assign a_fire         = master_a_valid & master_a_ready;
   assign d_fire         = master_d_valid;

   assign busy = (state_q == ISSUE) || (state_q == DRAIN);
   assign done = (state_q == DONE);
   assign err  = err_q;

   always_comb begin
      state_d       = state_q;
      beat_idx_d    = beat_idx_q;
      count_d       = count_q;
      base_d        = base_q;
      outstanding_d = outstanding_q;
      start_acc     = start && (state_q == IDLE);
      misaligned    = (base_addr[2:0] != 3'b000);
      last_beat     = (beat_idx_q == count_q - COUNT_W'(1));
      d_bad         = d_fire && (master_d_denied || master_d_corrupt ||
                                 (master_d_opcode != TL_OP_ACCESSACK));
      d_orphan      = d_fire && (outstanding_q == '0);

      case ({a_fire, d_fire})
         2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
         2'b01:   outstanding_d = d_orphan ? '0 : outstanding_q - OUT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase

      // A new start clears the sticky error; response errors in the same cycle still win.
      err_d = (start_acc ? misaligned : err_q) | d_bad | d_orphan;

      if (start_acc) begin
         base_d     = base_addr;
         count_d    = word_count;
         beat_idx_d = '0;
      end else if (a_fire) begin
         beat_idx_d = beat_idx_q + COUNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start_acc) begin
               if (misaligned || (word_count == '0)) state_d = DONE;
               else                                  state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (a_fire && last_beat) state_d = DRAIN;
         end
         DRAIN: begin
            // Looking at the updated count lets done follow the final ack by one cycle.
            if (outstanding_d == '0) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         beat_idx_q    <= '0;
         count_q       <= '0;
         base_q        <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_idx_q    <= beat_idx_d;
         count_q       <= count_d;
         base_q        <= base_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

endmodule
